mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter.sv | 148 ++++++++++++++
 tb/tb_mux_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// Two-requester burst arbiter feeding a single registered output slot.
// A and B share one output register through a select mux. Each grant may run
// up to MAX_BURST accepted beats while the other side waits, then the grant
// passes over. Ties from IDLE go to the side that was not granted last.
module mux_arbiter #(
   parameter int WIDTH     = 4,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic [WIDTH-1:0] data_a,
   output logic             ack_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_b,
   output logic             ack_b,
   output logic             sel,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   // The beat counter is 4 bits wide, so the burst limit must fit in 1..15.
   if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
      $error("mux_arbiter: MAX_BURST must be in the range 1..15");
   end

   localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             last_gnt;      // 0 = A was granted last, 1 = B
   logic             last_gnt_nxt;
   logic [3:0]       count;
   logic [3:0]       count_nxt;
   logic             can_accept;
   logic             beat_ack;
   logic [WIDTH-1:0] beat_data;

   // True when the beat being accepted now completes a full burst.
   function automatic logic burst_done(input logic [3:0] cnt);
      return (cnt + 4'd1) == BURST_LIM;
   endfunction

   // Handshake: the output slot is free when empty or being drained this cycle.
   always_comb begin
      can_accept = !out_valid || out_ready;
      ack_a      = (state == GNT_A) && req_a && can_accept;
      ack_b      = (state == GNT_B) && req_b && can_accept;
      sel        = (state == GNT_B);
      beat_ack   = ack_a || ack_b;
      beat_data  = sel ? data_b : data_a;
   end

   // Next grant, burst count and tie-break history.
   always_comb begin
      state_nxt    = state;
      count_nxt    = count;
      last_gnt_nxt = last_gnt;
      case (state)
         IDLE: begin
            if (req_a && req_b) begin
               state_nxt = last_gnt ? GNT_A : GNT_B;
            end else if (req_a) begin
               state_nxt = GNT_A;
            end else if (req_b) begin
               state_nxt = GNT_B;
            end
         end
         GNT_A: begin
            if (!req_a) begin
               state_nxt = req_b ? GNT_B : IDLE;
            end else if (ack_a) begin
               if (burst_done(count)) begin
                  // Full burst: hand over if B waits, otherwise start a fresh burst.
                  count_nxt = '0;
                  if (req_b) begin
                     state_nxt = GNT_B;
                  end
               end else begin
                  count_nxt = count + 4'd1;
               end
            end
            // req_a high without ack is a downstream stall: hold everything.
         end
         GNT_B: begin
            if (!req_b) begin
               state_nxt = req_a ? GNT_A : IDLE;
            end else if (ack_b) begin
               if (burst_done(count)) begin
                  count_nxt = '0;
                  if (req_a) begin
                     state_nxt = GNT_A;
                  end
               end else begin
                  count_nxt = count + 4'd1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Any change of grant restarts the burst; entering a grant records the winner.
      if (state_nxt != state) begin
         count_nxt = '0;
         if (state_nxt == GNT_A) begin
            last_gnt_nxt = 1'b0;
         end else if (state_nxt == GNT_B) begin
            last_gnt_nxt = 1'b1;
         end
      end
   end

   // Control registers; reset leaves B as last winner so A takes the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
         count    <= '0;
      end else begin
         state    <= state_nxt;
         last_gnt <= last_gnt_nxt;
         count    <= count_nxt;
      end
   end

   // Output slot: load on ack (even while draining, so no bubble), else empty on drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (beat_ack) begin
         out_valid <= 1'b1;
         out_data  <= beat_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: two instances (MAX_BURST 4 and 1) on shared inputs,
// each tracked by a behavioural model of grant ownership and the output slot.
module tb_mux_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_a, req_b, out_ready;
   logic [3:0] data_a, data_b;

   logic       ack_a0, ack_b0, sel0, ov0;
   logic [3:0] od0;
   logic       ack_a1, ack_b1, sel1, ov1;
   logic [3:0] od1;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: owner 0 = nobody, 1 = A, 2 = B; last winner 1 = A, 2 = B.
   int         mb[2]     = '{4, 1};
   int         m_own[2]  = '{0, 0};
   int         m_last[2] = '{2, 2};
   int         m_cnt[2]  = '{0, 0};
   int         m_ov[2]   = '{0, 0};
   logic [3:0] m_od[2];
   logic [7:0] e_vec[2];

   always #5 clk = ~clk;

   mux_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut0 (
      .clk(clk), .rst(rst),
      .req_a(req_a), .data_a(data_a), .ack_a(ack_a0),
      .req_b(req_b), .data_b(data_b), .ack_b(ack_b0),
      .sel(sel0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready)
   );

   mux_arbiter #(.WIDTH(4), .MAX_BURST(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_a(req_a), .data_a(data_a), .ack_a(ack_a1),
      .req_b(req_b), .data_b(data_b), .ack_b(ack_b1),
      .sel(sel1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready)
   );

   function automatic logic [7:0] obs(input int i);
      if (i == 0) return {sel0, ack_a0, ack_b0, ov0, od0};
      return {sel1, ack_a1, ack_b1, ov1, od1};
   endfunction

   function automatic logic model_ack(input int i, input int side);
      logic ca;
      logic rq;
      ca = (m_ov[i] == 0) || out_ready;
      rq = (side == 1) ? req_a : req_b;
      return (m_own[i] == side) && rq && ca;
   endfunction

   // Expected observable outputs for the current model state and inputs.
   task automatic eval();
      for (int i = 0; i < 2; i++) begin
         e_vec[i] = {(m_own[i] == 2), model_ack(i, 1), model_ack(i, 2), (m_ov[i] != 0), m_od[i]};
      end
   endtask

   // One clock: decide what each arbiter should do under the present inputs, then commit.
   task automatic advance();
      int         own_n[2], last_n[2], cnt_n[2], ov_n[2];
      logic [3:0] od_n[2];
      for (int i = 0; i < 2; i++) begin
         own_n[i] = m_own[i]; last_n[i] = m_last[i]; cnt_n[i] = m_cnt[i];
         ov_n[i] = m_ov[i]; od_n[i] = m_od[i];
         if (rst) begin
            own_n[i] = 0; last_n[i] = 2; cnt_n[i] = 0; ov_n[i] = 0; od_n[i] = 4'h0;
         end else begin
            int  me, other;
            logic acked, want_me, want_other;
            me = m_own[i];
            acked = model_ack(i, 1) || model_ack(i, 2);
            if (acked) begin
               ov_n[i] = 1;
               od_n[i] = (me == 1) ? data_a : data_b;
            end else if (out_ready) begin
               ov_n[i] = 0;
            end
            if (me == 0) begin
               if (req_a && req_b) own_n[i] = 3 - m_last[i];
               else if (req_a)     own_n[i] = 1;
               else if (req_b)     own_n[i] = 2;
            end else begin
               other      = 3 - me;
               want_me    = (me == 1) ? req_a : req_b;
               want_other = (other == 1) ? req_a : req_b;
               if (!want_me) begin
                  own_n[i] = want_other ? other : 0;
               end else if (acked) begin
                  cnt_n[i] = m_cnt[i] + 1;
                  if (cnt_n[i] == mb[i]) begin
                     cnt_n[i] = 0;
                     if (want_other) own_n[i] = other;
                  end
               end
            end
            if (own_n[i] != m_own[i]) begin
               cnt_n[i] = 0;
               if (own_n[i] != 0) last_n[i] = own_n[i];
            end
         end
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         m_own[i] = own_n[i]; m_last[i] = last_n[i]; m_cnt[i] = cnt_n[i];
         m_ov[i] = ov_n[i]; m_od[i] = od_n[i];
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
      data_a = 4'h0; data_b = 4'h0;
      advance();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
      data_a = 4'hA; data_b = 4'hB;
      advance();
      advance();
      rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
      #1;
      eval();
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (obs(i) !== 8'h00) $display("FAIL reset_state dut%0d: got %h want %h", i, obs(i), 8'h00);
         else n_pass++;
      end
      advance();
   endtask

   task automatic test_tie_alternation();
      do_reset();
      req_a = 1'b1; req_b = 1'b1; data_a = 4'h3; data_b = 4'h5; out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #1;
         eval();
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs(i) !== e_vec[i]) $display("FAIL tie_model dut%0d k=%0d: got %h want %h", i, k, obs(i), e_vec[i]);
            else n_pass++;
         end
         if (k >= 1) begin
            n_checks++;
            if (sel0 !== 1'(((k - 1) / 4) % 2)) $display("FAIL tie_sel_burst4 k=%0d: got %b want %b", k, sel0, 1'(((k - 1) / 4) % 2));
            else n_pass++;
            n_checks++;
            if (sel1 !== 1'((k - 1) % 2)) $display("FAIL tie_sel_burst1 k=%0d: got %b want %b", k, sel1, 1'((k - 1) % 2));
            else n_pass++;
         end
         if (k >= 2) begin
            n_checks++;
            if (od0 !== ((((k - 2) / 4) % 2 == 1) ? 4'h5 : 4'h3))
               $display("FAIL tie_beats_burst4 k=%0d: got %h want %h", k, od0, ((((k - 2) / 4) % 2 == 1) ? 4'h5 : 4'h3));
            else n_pass++;
            n_checks++;
            if (od1 !== ((((k - 2) % 2) == 1) ? 4'h5 : 4'h3))
               $display("FAIL tie_beats_burst1 k=%0d: got %h want %h", k, od1, ((((k - 2) % 2) == 1) ? 4'h5 : 4'h3));
            else n_pass++;
         end
         advance();
      end
   endtask

   task automatic test_single_requester();
      do_reset();
      req_a = 1'b0; req_b = 1'b1; data_b = 4'h9; out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         #1;
         eval();
         n_checks++;
         if (obs(0) !== e_vec[0]) $display("FAIL single_model k=%0d: got %h want %h", k, obs(0), e_vec[0]);
         else n_pass++;
         if (k >= 2) begin
            n_checks++;
            if ({sel0, ov0, od0} !== 6'b1_1_1001) $display("FAIL single_stream k=%0d: got %b want %b", k, {sel0, ov0, od0}, 6'b1_1_1001);
            else n_pass++;
         end
         advance();
      end
   endtask

   task automatic test_stall();
      logic [3:0] held;
      held = 4'h0;
      do_reset();
      req_a = 1'b1; req_b = 1'b0;
      for (int k = 0; k < 10; k++) begin
         data_a = 4'($urandom);
         out_ready = (k < 4 || k > 6);
         #1;
         eval();
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs(i) !== e_vec[i]) $display("FAIL stall_model dut%0d k=%0d: got %h want %h", i, k, obs(i), e_vec[i]);
            else n_pass++;
         end
         if (k == 4) held = od0;
         if (k >= 4 && k <= 6) begin
            n_checks++;
            if ({ack_a0, od0} !== {1'b0, held}) $display("FAIL stall_hold k=%0d: got %b want %b", k, {ack_a0, od0}, {1'b0, held});
            else n_pass++;
         end
         if (k == 7) begin
            n_checks++;
            if (ack_a0 !== 1'b1) $display("FAIL stall_resume: got %b want 1", ack_a0);
            else n_pass++;
         end
         advance();
      end
   endtask

   task automatic test_drop_switch();
      int n_acka;
      n_acka = 0;
      do_reset();
      req_b = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         req_a = (k < 3);
         data_a = 4'($urandom); data_b = 4'($urandom);
         #1;
         eval();
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs(i) !== e_vec[i]) $display("FAIL drop_model dut%0d k=%0d: got %h want %h", i, k, obs(i), e_vec[i]);
            else n_pass++;
         end
         if (ack_a0 === 1'b1) n_acka++;
         if (k == 4) begin
            n_checks++;
            if ({sel0, ack_b0} !== 2'b11) $display("FAIL drop_switch: got %b want %b", {sel0, ack_b0}, 2'b11);
            else n_pass++;
         end
         advance();
      end
      n_checks++;
      if (n_acka != 2) $display("FAIL drop_beat_count: got %0d want 2", n_acka);
      else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      req_a = 1'b1; req_b = 1'b1; data_a = 4'h6; data_b = 4'hC; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) advance();
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      eval();
      n_checks++;
      if (obs(0) !== e_vec[0]) $display("FAIL midrst_before: got %h want %h", obs(0), e_vec[0]);
      else n_pass++;
      advance();
      rst = 1'b0; out_ready = 1'b1;
      #1;
      n_checks++;
      if ({sel0, ack_a0, ack_b0, ov0, od0} !== 8'h00) $display("FAIL midrst_cleared: got %h want %h", obs(0), 8'h00);
      else n_pass++;
      eval();
      advance();
      #1;
      n_checks++;
      if ({sel0, ack_a0} !== 2'b01) $display("FAIL midrst_tie_a: got %b want %b", {sel0, ack_a0}, 2'b01);
      else n_pass++;
      eval();
      advance();
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         rst       = ($urandom_range(0, 63) == 0);
         req_a     = ($urandom_range(0, 3) != 0);
         req_b     = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         data_a    = 4'($urandom);
         data_b    = 4'($urandom);
         #1;
         eval();
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs(i) !== e_vec[i]) $display("FAIL random_model dut%0d k=%0d: got %h want %h", i, k, obs(i), e_vec[i]);
            else n_pass++;
         end
         advance();
      end
      rst = 1'b0;
   endtask

   initial begin
      m_od[0] = 4'h0;
      m_od[1] = 4'h0;
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
      data_a = 4'h0; data_b = 4'h0;
      @(negedge clk);
      test_reset();
      test_tie_alternation();
      test_single_requester();
      test_stall();
      test_drop_switch();
      test_reset_mid_burst();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
